// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared vector/matrix/result memory port.
// Clients: host write (hw), result write-back (rw), host read (hr).
//   clk/reset        : clock, async active-high reset
//   x_valid/x_ready  : burst handshakes, x_addr/x_data/x_last beat fields
//   hr_rdata/rvalid  : read return, one cycle after an accepted hr beat
//   mem_*            : memory port (synchronous read data)
//   owner/busy       : current grant (0 none, 1 hw, 2 rw, 3 hr)
//   addr_err/timeout_err : sticky flags, cleared by err_clr
module mem_port_arbiter #(
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned WORD_SIZE = 16,
  parameter logic [ADDR_SIZE-1:0] MEM_LIMIT = 10'h3ff,
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hw_valid,
  output logic                 hw_ready,
  input  logic [ADDR_SIZE-1:0] hw_addr,
  input  logic [WORD_SIZE-1:0] hw_data,
  input  logic                 hw_last,
  input  logic                 rw_valid,
  output logic                 rw_ready,
  input  logic [ADDR_SIZE-1:0] rw_addr,
  input  logic [WORD_SIZE-1:0] rw_data,
  input  logic                 rw_last,
  input  logic                 hr_valid,
  output logic                 hr_ready,
  input  logic [ADDR_SIZE-1:0] hr_addr,
  input  logic                 hr_last,
  output logic [WORD_SIZE-1:0] hr_rdata,
  output logic                 hr_rvalid,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_w_data,
  output logic                 mem_w_en,
  output logic                 mem_r_en,
  input  logic [WORD_SIZE-1:0] mem_r_data,
  output logic [1:0]           owner,
  output logic                 busy,
  output logic                 addr_err,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [1:0] O_NONE = 2'd0;
  localparam logic [1:0] O_HW   = 2'd1;
  localparam logic [1:0] O_RW   = 2'd2;
  localparam logic [1:0] O_HR   = 2'd3;

  state_t         state_q;
  logic [1:0]     owner_q;
  logic [1:0]     last_q;
  logic [7:0]     wdog_q;
  logic [7:0]     wdog_d;
  logic           rvalid_q;
  logic           rinr_q;
  logic           aerr_q;
  logic           terr_q;

  logic [1:0]     pick_d;
  logic           own_valid;
  logic           own_last;
  logic [ADDR_SIZE-1:0] own_addr;
  logic [WORD_SIZE-1:0] own_wdata;
  logic           xfer;
  logic           in_range;
  logic           wdog_hit;

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    unique case (owner_q)
      O_HW: begin
        own_valid = hw_valid;
        own_last  = hw_last;
        own_addr  = hw_addr;
        own_wdata = hw_data;
      end
      O_RW: begin
        own_valid = rw_valid;
        own_last  = rw_last;
        own_addr  = rw_addr;
        own_wdata = rw_data;
      end
      O_HR: begin
        own_valid = hr_valid;
        own_last  = hr_last;
        own_addr  = hr_addr;
      end
      default: ;
    endcase
  end

  // Search starts at the client after the previous owner.
  always_comb begin
    pick_d = O_NONE;
    unique case (last_q)
      O_HW: begin
        if (rw_valid)      pick_d = O_RW;
        else if (hr_valid) pick_d = O_HR;
        else if (hw_valid) pick_d = O_HW;
      end
      O_RW: begin
        if (hr_valid)      pick_d = O_HR;
        else if (hw_valid) pick_d = O_HW;
        else if (rw_valid) pick_d = O_RW;
      end
      default: begin
        if (hw_valid)      pick_d = O_HW;
        else if (rw_valid) pick_d = O_RW;
        else if (hr_valid) pick_d = O_HR;
      end
    endcase
  end

  // Ready is only ever high for the owner, so owner valid is the transfer.
  assign xfer     = own_valid;
  assign in_range = ({1'b0, own_addr} <= {1'b0, MEM_LIMIT});
  assign wdog_d   = wdog_q + 8'd1;
  assign wdog_hit = (state_q == S_GRANT) && !xfer
                    && (wdog_d == TIMEOUT);

  assign hw_ready   = (owner_q == O_HW);
  assign rw_ready   = (owner_q == O_RW);
  assign hr_ready   = (owner_q == O_HR);
  assign owner      = owner_q;
  assign busy       = (owner_q != O_NONE);
  assign mem_addr   = own_addr;
  assign mem_w_data = own_wdata;
  assign mem_w_en   = xfer && in_range
                      && (owner_q == O_HW || owner_q == O_RW);
  assign mem_r_en   = xfer && in_range && (owner_q == O_HR);
  assign hr_rvalid  = rvalid_q;
  assign hr_rdata   = (rvalid_q && rinr_q) ? mem_r_data : '0;
  assign addr_err   = aerr_q;
  assign timeout_err = terr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= O_NONE;
      last_q   <= O_HR;
      wdog_q   <= 8'd0;
      rvalid_q <= 1'b0;
      rinr_q   <= 1'b0;
      aerr_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      rvalid_q <= xfer && (owner_q == O_HR);
      rinr_q   <= in_range;
      if (xfer && !in_range) aerr_q <= 1'b1;
      else if (err_clr)      aerr_q <= 1'b0;
      if (wdog_hit)          terr_q <= 1'b1;
      else if (err_clr)      terr_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          wdog_q <= 8'd0;
          if (pick_d != O_NONE) begin
            owner_q <= pick_d;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (xfer) begin
            wdog_q <= 8'd0;
            if (own_last) begin
              last_q  <= owner_q;
              owner_q <= O_NONE;
              state_q <= S_IDLE;
            end
          end else if (wdog_hit) begin
            wdog_q  <= 8'd0;
            last_q  <= owner_q;
            owner_q <= O_NONE;
            state_q <= S_IDLE;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed bursts then random
// traffic, checked against a burst-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam logic [9:0] LIM = 10'h3fe;
  localparam logic [7:0] TO  = 8'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hw_valid, hw_ready, hw_last;
  logic [9:0]  hw_addr;
  logic [15:0] hw_data;
  logic        rw_valid, rw_ready, rw_last;
  logic [9:0]  rw_addr;
  logic [15:0] rw_data;
  logic        hr_valid, hr_ready, hr_last;
  logic [9:0]  hr_addr;
  logic [15:0] hr_rdata;
  logic        hr_rvalid;
  logic [9:0]  mem_addr;
  logic [15:0] mem_w_data;
  logic        mem_w_en, mem_r_en;
  logic [15:0] mem_r_data;
  logic [1:0]  owner;
  logic        busy, addr_err, timeout_err;
  logic        err_clr = 1'b0;

  mem_port_arbiter #(
    .ADDR_SIZE(10), .WORD_SIZE(16),
    .MEM_LIMIT(LIM), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .hw_valid(hw_valid), .hw_ready(hw_ready),
    .hw_addr(hw_addr), .hw_data(hw_data), .hw_last(hw_last),
    .rw_valid(rw_valid), .rw_ready(rw_ready),
    .rw_addr(rw_addr), .rw_data(rw_data), .rw_last(rw_last),
    .hr_valid(hr_valid), .hr_ready(hr_ready),
    .hr_addr(hr_addr), .hr_last(hr_last),
    .hr_rdata(hr_rdata), .hr_rvalid(hr_rvalid),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .mem_r_data(mem_r_data),
    .owner(owner), .busy(busy),
    .addr_err(addr_err), .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory environment: synchronous read, one cycle latency.
  logic [15:0] mem [0:1023];
  logic [15:0] ref_mem [0:1023];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= mem[mem_addr];
  end

  // Requester drivers: each client plays beats from its own queue.
  typedef struct {
    logic [9:0]  a;
    logic [15:0] d;
    logic        l;
    int          gap;
  } beat_t;

  beat_t       bq [1:3][$];
  logic        dv [1:3];
  logic [9:0]  da [1:3];
  logic [15:0] dd [1:3];
  logic        dl [1:3];
  int          gapc [1:3];
  bit          fresh [1:3];
  bit          acc [1:3];
  bit          rnd = 1'b0;
  bit          clr_req = 1'b0;

  assign hw_valid = dv[1];
  assign hw_addr  = da[1];
  assign hw_data  = dd[1];
  assign hw_last  = dl[1];
  assign rw_valid = dv[2];
  assign rw_addr  = da[2];
  assign rw_data  = dd[2];
  assign rw_last  = dl[2];
  assign hr_valid = dv[3];
  assign hr_addr  = da[3];
  assign hr_last  = dl[3];

  function automatic bit rdy(input int i);
    case (i)
      1: return hw_ready;
      2: return rw_ready;
      default: return hr_ready;
    endcase
  endfunction

  initial begin
    for (int i = 1; i <= 3; i++) begin
      dv[i] = 1'b0; da[i] = '0; dd[i] = '0;
      dl[i] = 1'b0; gapc[i] = 0; fresh[i] = 1'b1;
    end
    forever begin
      @(posedge clk);
      for (int i = 1; i <= 3; i++) acc[i] = dv[i] && rdy(i);
      #1;
      for (int i = 1; i <= 3; i++) begin
        if (reset) begin
          bq[i].delete();
          dv[i] = 1'b0; gapc[i] = 0; fresh[i] = 1'b1;
        end else begin
          if (acc[i]) begin
            bq[i].delete(0);
            fresh[i] = 1'b1;
          end
          if (bq[i].size() == 0) begin
            dv[i] = 1'b0;
          end else begin
            if (fresh[i]) begin
              gapc[i] = bq[i][0].gap;
              fresh[i] = 1'b0;
            end
            da[i] = bq[i][0].a;
            dd[i] = (i == 3) ? 16'h0 : bq[i][0].d;
            dl[i] = bq[i][0].l;
            if (gapc[i] > 0) begin
              dv[i] = 1'b0;
              gapc[i]--;
            end else begin
              dv[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
          end
        end
      end
      err_clr = clr_req || (rnd && $urandom_range(0, 15) == 0);
      clr_req = 1'b0;
    end
  end

  // Reference model: grant bookkeeping in plain integers.
  typedef struct {
    int          own;
    bit          aerr;
    bit          terr;
    bit          rv;
    logic [15:0] rd;
    bit          wen;
    bit          ren;
    logic [9:0]  addr;
    logic [15:0] wd;
  } exp_t;

  exp_t        exp_q [$];
  int          m_own = 0;
  int          m_prev = 3;
  int          m_idle = 0;
  bit          m_aerr = 1'b0;
  bit          m_terr = 1'b0;
  bit          m_rv = 1'b0;
  logic [15:0] m_rd = '0;

  always @(negedge clk) begin
    exp_t e;
    bit x, inr, found, tflag;
    int c;
    logic        vv [1:3];
    logic [9:0]  aa [1:3];
    logic [15:0] ww [1:3];
    logic        ll [1:3];
    vv[1] = hw_valid; aa[1] = hw_addr; ww[1] = hw_data; ll[1] = hw_last;
    vv[2] = rw_valid; aa[2] = rw_addr; ww[2] = rw_data; ll[2] = rw_last;
    vv[3] = hr_valid; aa[3] = hr_addr; ww[3] = 16'h0;   ll[3] = hr_last;
    if (reset) begin
      m_own = 0; m_prev = 3; m_idle = 0;
      m_aerr = 1'b0; m_terr = 1'b0; m_rv = 1'b0;
    end
    e.own  = m_own;
    e.aerr = m_aerr;
    e.terr = m_terr;
    e.rv   = m_rv;
    e.rd   = m_rd;
    e.addr = (m_own != 0) ? aa[m_own] : 10'h0;
    e.wd   = (m_own == 1 || m_own == 2) ? ww[m_own] : 16'h0;
    x      = !reset && m_own != 0 && vv[m_own];
    inr    = (e.addr <= LIM);
    e.wen  = x && m_own != 3 && inr;
    e.ren  = x && m_own == 3 && inr;
    exp_q.push_back(e);
    if (!reset) begin
      if (e.wen) ref_mem[e.addr] = e.wd;
      m_rv = x && m_own == 3;
      m_rd = (m_rv && inr) ? ref_mem[e.addr] : 16'h0;
      if (x && !inr) m_aerr = 1'b1;
      else if (err_clr) m_aerr = 1'b0;
      tflag = 1'b0;
      if (m_own == 0) begin
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          c = (m_prev + k - 1) % 3 + 1;
          if (!found && vv[c]) begin
            m_own = c; m_idle = 0; found = 1'b1;
          end
        end
      end else if (x) begin
        m_idle = 0;
        if (ll[m_own]) begin
          m_prev = m_own; m_own = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == int'(TO)) begin
          m_prev = m_own; m_own = 0; m_idle = 0; tflag = 1'b1;
        end
      end
      if (tflag) m_terr = 1'b1;
      else if (err_clr) m_terr = 1'b0;
    end
  end

  // Monitor: pops the expectation for each cycle and compares.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("owner", 32'(owner), 32'(e.own));
      chk("hw_ready", 32'(hw_ready), 32'(e.own == 1));
      chk("rw_ready", 32'(rw_ready), 32'(e.own == 2));
      chk("hr_ready", 32'(hr_ready), 32'(e.own == 3));
      chk("busy", 32'(busy), 32'(e.own != 0));
      chk("addr_err", 32'(addr_err), 32'(e.aerr));
      chk("timeout_err", 32'(timeout_err), 32'(e.terr));
      chk("hr_rvalid", 32'(hr_rvalid), 32'(e.rv));
      if (e.rv) chk("hr_rdata", 32'(hr_rdata), 32'(e.rd));
      chk("mem_w_en", 32'(mem_w_en), 32'(e.wen));
      chk("mem_r_en", 32'(mem_r_en), 32'(e.ren));
      chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      chk("mem_w_data", 32'(mem_w_data), 32'(e.wd));
    end
  end

  task automatic push(input int r, input logic [9:0] a,
                      input logic [15:0] d, input bit l, input int g);
    beat_t b;
    b.a = a; b.d = d; b.l = l; b.gap = g;
    bq[r].push_back(b);
  endtask

  function automatic int pending();
    return bq[1].size() + bq[2].size() + bq[3].size();
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && (pending() != 0 || busy)) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) chk("drain_timeout", 32'(n), 32'(budget - 1));
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); @(posedge clk); #2 reset = 1'b0;
  endtask

  initial begin
    int n, r, len;
    logic [9:0] a;
    for (int i = 0; i < 1024; i++) begin
      mem[i] <= 16'(i * 7) ^ 16'h1357;
      ref_mem[i] = 16'(i * 7) ^ 16'h1357;
    end
    mem[10'h20] <= 16'hA5A5; ref_mem[10'h20] = 16'hA5A5;
    mem[10'h21] <= 16'h5A5A; ref_mem[10'h21] = 16'h5A5A;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Simultaneous 2-beat bursts from reset: order hw, rw, hr.
    push(1, 10'h100, 16'h1111, 1'b0, 0);
    push(1, 10'h101, 16'h1112, 1'b1, 0);
    push(2, 10'h200, 16'h2221, 1'b0, 0);
    push(2, 10'h201, 16'h2222, 1'b1, 0);
    push(3, 10'h100, 16'h0, 1'b0, 0);
    push(3, 10'h201, 16'h0, 1'b1, 0);
    wait_idle(100);

    // hw 3-beat write burst.
    pulse_reset();
    for (int i = 0; i < 3; i++)
      push(1, 10'(16 + i), 16'(16'hC000 + i), i == 2, 0);
    wait_idle(100);

    // hr 2-beat read of preloaded words.
    push(3, 10'h20, 16'h0, 1'b0, 0);
    push(3, 10'h21, 16'h0, 1'b1, 0);
    wait_idle(100);

    // Out-of-range rw write, then clear.
    push(2, 10'h3ff, 16'hDEAD, 1'b1, 0);
    wait_idle(100);
    chk("addr_err_set", 32'(addr_err), 32'd1);
    clr_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("addr_err_clr", 32'(addr_err), 32'd0);

    // hw stalls mid-burst; watchdog hands over to rw.
    push(1, 10'h40, 16'h4040, 1'b0, 0);
    push(1, 10'h41, 16'h4141, 1'b1, 6);
    push(2, 10'h50, 16'h5050, 1'b1, 0);
    wait_idle(200);
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    clr_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("timeout_err_clr", 32'(timeout_err), 32'd0);

    // Reset in the middle of a 4-beat rw burst.
    for (int i = 0; i < 4; i++)
      push(2, 10'(96 + i), 16'(16'h6000 + i), i == 3, 0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!rw_ready && n < 20);
    chk("rw_grant_seen", 32'(rw_ready), 32'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_rw_ready", 32'(rw_ready), 32'd0);
    chk("rst_mem_w_en", 32'(mem_w_en), 32'd0);
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b0;
    push(2, 10'h70, 16'h7070, 1'b1, 0);
    push(1, 10'h71, 16'h7171, 1'b1, 0);
    wait_idle(100);

    // Random traffic.
    rnd = 1'b1;
    for (int b = 0; b < 60; b++) begin
      r = $urandom_range(1, 3);
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        a = ($urandom_range(0, 7) == 0) ? 10'h3ff
            : 10'($urandom_range(0, 1023));
        push(r, a, 16'($urandom), i == len - 1,
             ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 1));
      end
      n = 0;
      while (pending() > 8 && n < 400) begin
        @(posedge clk);
        n++;
      end
      if (n >= 400) chk("rand_backlog", 32'(pending()), 32'd8);
    end
    wait_idle(4000);
    rnd = 1'b0;
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
